// File: rtl/ysyx_24100012_imem_resp_if.sv
// rtl/ysyx_24100012_imem_resp_if.sv - fetch request/response and array write port bundle
interface ysyx_24100012_imem_resp_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_err;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [3:0]            wr_mask;

  modport master (
    output req_valid, req_addr, resp_ready, wr_en, wr_addr, wr_data, wr_mask,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready, wr_en, wr_addr, wr_data, wr_mask,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/ysyx_24100012_imem_resp.sv
// rtl/ysyx_24100012_imem_resp.sv - instruction-memory responder with fixed programmable fetch latency
module ysyx_24100012_imem_resp #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] ORIGIN_ADDR = 32'h80000000,
  parameter int                    MEM_SIZE    = 4096,
  parameter int                    LATENCY     = 1
) (
  input logic                      clk,
  input logic                      rst,
  ysyx_24100012_imem_resp_if.slave bus
);
  localparam int WORDS = MEM_SIZE / 4;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] LO = {1'b0, ORIGIN_ADDR};
  localparam logic [ADDR_WIDTH:0] HI = LO + (ADDR_WIDTH+1)'(MEM_SIZE);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic                  accept;
  logic                  rd_err;
  logic                  wr_ok;
  logic [IDX_W-1:0]      rd_idx;
  logic [IDX_W-1:0]      wr_idx;

  assign accept = bus.req_valid && (state_q == IDLE);
  assign rd_err = (bus.req_addr[1:0] != 2'b00)
               || ({1'b0, bus.req_addr} < LO)
               || ({1'b0, bus.req_addr} >= HI);
  // Low index bits of (addr - origin) depend only on the low bits of each operand.
  assign rd_idx = bus.req_addr[IDX_W+1:2] - ORIGIN_ADDR[IDX_W+1:2];
  assign wr_idx = bus.wr_addr[IDX_W+1:2] - ORIGIN_ADDR[IDX_W+1:2];
  // Origin is word aligned, so the full address range-checks the same as its word.
  assign wr_ok  = ({1'b0, bus.wr_addr} >= LO) && ({1'b0, bus.wr_addr} < HI);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        data_q <= rd_err ? '0 : mem[rd_idx];
        err_q  <= rd_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.wr_en && wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wr_mask[b]) mem[wr_idx][8*b +: 8] <= bus.wr_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 8'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.resp_data = data_q;
  assign bus.resp_err  = err_q;
endmodule

// File: tb/tb_ysyx_24100012_imem_resp.sv
// tb/tb_ysyx_24100012_imem_resp.sv - scoreboard bench for the imem responder at latencies 1, 3 and 4
module tb_ysyx_24100012_imem_resp;
  localparam logic [31:0] ORG = 32'h80000000;
  localparam int          MSZ = 4096;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  sel = 2'd0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        resp_ready = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_mask = '0;

  logic        o_req_ready, o_resp_valid, o_resp_err;
  logic [31:0] o_resp_data;

  int total = 0;
  int bad   = 0;

  resp_t       exp_q[$];
  logic [31:0] model [1024];

  ysyx_24100012_imem_resp_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b1 ();
  ysyx_24100012_imem_resp_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b3 ();
  ysyx_24100012_imem_resp_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b4 ();

  ysyx_24100012_imem_resp #(.LATENCY(1)) u_lat1 (.clk(clk), .rst(rst), .bus(b1));
  ysyx_24100012_imem_resp #(.LATENCY(3)) u_lat3 (.clk(clk), .rst(rst), .bus(b3));
  ysyx_24100012_imem_resp #(.LATENCY(4)) u_lat4 (.clk(clk), .rst(rst), .bus(b4));

  assign b1.req_valid  = req_valid && (sel == 2'd0);
  assign b3.req_valid  = req_valid && (sel == 2'd1);
  assign b4.req_valid  = req_valid && (sel == 2'd2);
  assign b1.resp_ready = resp_ready && (sel == 2'd0);
  assign b3.resp_ready = resp_ready && (sel == 2'd1);
  assign b4.resp_ready = resp_ready && (sel == 2'd2);
  assign b1.req_addr = req_addr;
  assign b3.req_addr = req_addr;
  assign b4.req_addr = req_addr;
  assign b1.wr_en = wr_en;
  assign b3.wr_en = wr_en;
  assign b4.wr_en = wr_en;
  assign b1.wr_addr = wr_addr;
  assign b3.wr_addr = wr_addr;
  assign b4.wr_addr = wr_addr;
  assign b1.wr_data = wr_data;
  assign b3.wr_data = wr_data;
  assign b4.wr_data = wr_data;
  assign b1.wr_mask = wr_mask;
  assign b3.wr_mask = wr_mask;
  assign b4.wr_mask = wr_mask;

  always_comb begin
    o_req_ready  = b1.req_ready;
    o_resp_valid = b1.resp_valid;
    o_resp_data  = b1.resp_data;
    o_resp_err   = b1.resp_err;
    if (sel == 2'd1) begin
      o_req_ready  = b3.req_ready;
      o_resp_valid = b3.resp_valid;
      o_resp_data  = b3.resp_data;
      o_resp_err   = b3.resp_err;
    end else if (sel == 2'd2) begin
      o_req_ready  = b4.req_ready;
      o_resp_valid = b4.resp_valid;
      o_resp_data  = b4.resp_data;
      o_resp_err   = b4.resp_err;
    end
  end

  function automatic logic in_range(input logic [31:0] a);
    logic [32:0] e;
    e = {1'b0, a};
    return (e >= {1'b0, ORG}) && (e < ({1'b0, ORG} + 33'(MSZ)));
  endfunction

  function automatic resp_t expect_of(input logic [31:0] a);
    resp_t r;
    logic [9:0] idx;
    idx    = 10'((a - ORG) >> 2);
    r.err  = (a[1:0] != 2'b00) || !in_range(a);
    r.data = r.err ? 32'h0 : model[idx];
    return r;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [9:0] idx;
    idx = 10'((a - ORG) >> 2);
    if (in_range(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (m[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    @(negedge clk);
    wr_en = 1'b0;
    model_write(a, d, m);
  endtask

  task automatic drive_req(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    exp_q.push_back(expect_of(a));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int limit, output int n);
    n = 0;
    while (!o_resp_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      total++; if (o_req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready dut=%0d got=%b want=1", s, o_req_ready); end
      total++; if (o_resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid dut=%0d got=%b want=0", s, o_resp_valid); end
      total++; if (o_resp_data !== 32'h0) begin bad++; $display("FAIL reset_resp_data dut=%0d got=%h want=0", s, o_resp_data); end
      total++; if (o_resp_err !== 1'b0) begin bad++; $display("FAIL reset_resp_err dut=%0d got=%b want=0", s, o_resp_err); end
    end
    @(negedge clk);
  endtask

  task automatic preload();
    for (int w = 0; w < 32; w++) begin
      do_write(ORG + 32'(4 * w), (w == 0) ? 32'h00000413 : (w == 1) ? 32'hAABBCCDD : $urandom, 4'hF);
    end
    do_write(ORG + 32'hFFC, $urandom, 4'hF);
  endtask

  task automatic test_latency1();
    resp_t e;
    sel = 2'd0;
    #1;
    total++; if (o_req_ready !== 1'b1) begin bad++; $display("FAIL lat1_ready_before got=%b want=1", o_req_ready); end
    @(negedge clk);
    drive_req(ORG);
    e = exp_q.pop_front();
    total++; if (o_resp_valid !== 1'b1) begin bad++; $display("FAIL lat1_valid got=%b want=1", o_resp_valid); end
    total++; if (o_resp_data !== e.data) begin bad++; $display("FAIL lat1_data got=%h want=%h", o_resp_data, e.data); end
    total++; if (o_resp_err !== e.err) begin bad++; $display("FAIL lat1_err got=%b want=%b", o_resp_err, e.err); end
    total++; if (o_req_ready !== 1'b0) begin bad++; $display("FAIL lat1_ready_busy got=%b want=0", o_req_ready); end
    consume();
    total++; if (o_resp_valid !== 1'b0) begin bad++; $display("FAIL lat1_valid_after got=%b want=0", o_resp_valid); end
    total++; if (o_req_ready !== 1'b1) begin bad++; $display("FAIL lat1_ready_after got=%b want=1", o_req_ready); end
  endtask

  task automatic test_latency3();
    resp_t       e;
    logic [31:0] wd;
    int          n;
    sel = 2'd1;
    wd  = $urandom;
    drive_req(ORG + 32'h8);
    e = exp_q.pop_front();
    for (int c = 1; c <= 7; c++) begin
      if (c == 1) begin
        wr_en = 1'b1; wr_addr = ORG + 32'h8; wr_data = wd; wr_mask = 4'hF;
      end
      if (c == 2) begin
        wr_en = 1'b0;
        model_write(ORG + 32'h8, wd, 4'hF);
      end
      if (c < 3) begin
        total++; if (o_resp_valid !== 1'b0) begin bad++; $display("FAIL lat3_early_valid cyc=%0d got=%b want=0", c, o_resp_valid); end
        total++; if (o_req_ready !== 1'b0) begin bad++; $display("FAIL lat3_wait_ready cyc=%0d got=%b want=0", c, o_req_ready); end
      end else if (c <= 6) begin
        total++; if (o_resp_valid !== 1'b1) begin bad++; $display("FAIL lat3_valid cyc=%0d got=%b want=1", c, o_resp_valid); end
        total++; if (o_resp_data !== e.data) begin bad++; $display("FAIL lat3_data cyc=%0d got=%h want=%h", c, o_resp_data, e.data); end
        total++; if (o_req_ready !== 1'b0) begin bad++; $display("FAIL lat3_resp_ready cyc=%0d got=%b want=0", c, o_req_ready); end
        if (c == 6) resp_ready = 1'b1;
      end else begin
        resp_ready = 1'b0;
        total++; if (o_resp_valid !== 1'b0) begin bad++; $display("FAIL lat3_valid_after got=%b want=0", o_resp_valid); end
        total++; if (o_req_ready !== 1'b1) begin bad++; $display("FAIL lat3_ready_after got=%b want=1", o_req_ready); end
      end
      if (c < 7) @(negedge clk);
    end
    drive_req(ORG + 32'h8);
    wait_resp(10, n);
    total++; if (n != 2) begin bad++; $display("FAIL lat3_latency got=%0d want=2", n); end
    e = exp_q.pop_front();
    total++; if (o_resp_data !== e.data) begin bad++; $display("FAIL lat3_after_write got=%h want=%h", o_resp_data, e.data); end
    consume();
  endtask

  task automatic test_errors();
    logic [31:0] addrs [5];
    resp_t       e;
    int          n;
    addrs = '{32'h80000002, 32'h80001000, 32'h7FFFFFFC, 32'h80000FFC, 32'hFFFFFFFC};
    sel = 2'd0;
    foreach (addrs[i]) begin
      drive_req(addrs[i]);
      wait_resp(5, n);
      total++; if (n != 0) begin bad++; $display("FAIL err_latency addr=%h got=%0d want=0", addrs[i], n); end
      e = exp_q.pop_front();
      total++; if (o_resp_err !== e.err) begin bad++; $display("FAIL err_flag addr=%h got=%b want=%b", addrs[i], o_resp_err, e.err); end
      total++; if (o_resp_data !== e.data) begin bad++; $display("FAIL err_data addr=%h got=%h want=%h", addrs[i], o_resp_data, e.data); end
      consume();
    end
  endtask

  task automatic test_write_rules();
    logic [31:0] addrs [4];
    resp_t       e;
    int          n;
    sel = 2'd0;
    req_valid = 1'b1; req_addr = ORG + 32'h4;
    exp_q.push_back(expect_of(ORG + 32'h4));
    wr_en = 1'b1; wr_addr = ORG + 32'h4; wr_data = 32'h11223344; wr_mask = 4'b0011;
    @(negedge clk);
    req_valid = 1'b0; wr_en = 1'b0;
    model_write(ORG + 32'h4, 32'h11223344, 4'b0011);
    wait_resp(5, n);
    e = exp_q.pop_front();
    total++; if (o_resp_data !== e.data) begin bad++; $display("FAIL same_edge_data got=%h want=%h", o_resp_data, e.data); end
    consume();
    do_write(ORG + 32'h1000, 32'hDEADBEEF, 4'hF);
    do_write(ORG - 32'h4, 32'hCAFEF00D, 4'hF);
    do_write(ORG + 32'h16, 32'h5A000000, 4'b1000);
    addrs = '{ORG + 32'h4, ORG, ORG + 32'hFFC, ORG + 32'h14};
    foreach (addrs[i]) begin
      drive_req(addrs[i]);
      wait_resp(5, n);
      e = exp_q.pop_front();
      total++; if (o_resp_data !== e.data) begin bad++; $display("FAIL write_rule addr=%h got=%h want=%h", addrs[i], o_resp_data, e.data); end
      consume();
    end
  endtask

  task automatic test_reset_abort();
    resp_t e;
    int    n;
    sel = 2'd2;
    drive_req(ORG + 32'hC);
    void'(exp_q.pop_back());
    @(negedge clk);
    total++; if (o_req_ready !== 1'b0) begin bad++; $display("FAIL abort_wait_ready got=%b want=0", o_req_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (o_resp_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b want=0", o_resp_valid); end
    total++; if (o_req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", o_req_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (o_resp_valid !== 1'b0) begin bad++; $display("FAIL abort_stale_valid cyc=%0d got=%b want=0", c, o_resp_valid); end
    end
    drive_req(ORG + 32'h10);
    wait_resp(10, n);
    total++; if (n != 3) begin bad++; $display("FAIL abort_next_latency got=%0d want=3", n); end
    e = exp_q.pop_front();
    total++; if (o_resp_data !== e.data) begin bad++; $display("FAIL abort_next_data got=%h want=%h", o_resp_data, e.data); end
    consume();
  endtask

  task automatic test_back_to_back();
    resp_t       e;
    logic [31:0] pc;
    int          issued, got, last;
    sel = 2'd0;
    #1;
    resp_ready = 1'b1;
    pc = ORG; issued = 0; got = 0; last = -1;
    for (int cyc = 0; cyc < 80 && got < 16; cyc++) begin
      if (o_resp_valid) begin
        e = exp_q.pop_front();
        total++; if (o_resp_data !== e.data) begin bad++; $display("FAIL b2b_data n=%0d got=%h want=%h", got, o_resp_data, e.data); end
        if (last >= 0) begin
          total++; if (cyc - last != 2) begin bad++; $display("FAIL b2b_gap n=%0d got=%0d want=2", got, cyc - last); end
        end
        last = cyc;
        got++;
      end
      if (o_req_ready && issued < 16) begin
        req_valid = 1'b1; req_addr = pc;
        exp_q.push_back(expect_of(pc));
        pc += 32'h4;
        issued++;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    resp_ready = 1'b0;
    total++; if (got != 16) begin bad++; $display("FAIL b2b_count got=%0d want=16", got); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_leftover got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    preload();
    test_latency1();
    test_latency3();
    test_errors();
    test_write_rules();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
